// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory fetch controller:
// FSM state encoding, IM geometry, reset PC and the jump-target helper.
package im_pkg;

  localparam int          IM_DEPTH    = 32;
  localparam int          IM_ADDR_W   = 5;
  localparam logic [31:0] IM_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } im_state_t;

  // Jump target: top nibble of PC+4, 26-bit word field, word aligned.
  function automatic logic [31:0] jump_align(input logic [31:0] pc_plus4,
                                             input logic [25:0] addr26);
    return {pc_plus4[31:28], addr26, 2'b00};
  endfunction

endpackage

// File: rtl/im_next_pc.sv
// Combinational next-PC selection for the fetch controller.
// Priority: stall (hold) > jump > branch > sequential PC+4.
// The result is always word aligned.
module im_next_pc (
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        jmp_taken,
  input  logic [25:0] addr26,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic [31:0] next_pc
);
  import im_pkg::*;

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // Pick the redirect source by priority; low two bits forced to zero.
  always_comb begin
    next_pc = {pc_plus4[31:2], 2'b00};
    if (stall) begin
      next_pc = {pc[31:2], 2'b00};
    end else if (jmp_taken) begin
      next_pc = jump_align(pc_plus4, addr26);
    end else if (br_taken) begin
      next_pc = {br_target[31:2], 2'b00};
    end
  end

endmodule

// File: rtl/im_fetch_ctrl.sv
// Instruction-memory sequencer: owns the PC and shares the single IM port
// between the boot-time word loader and instruction fetch.
// Optional feature macro: IM_FETCH_BOUNDS_CHECK_EN -- when defined, a fetch
// whose word index leaves the IM halts the core with Fault=1; otherwise the
// IM index simply wraps and Fault stays 0.
//
// Overlong bursts: once the DEPTH-th word is taken without LdLast, LdReady
// drops for one cycle, then the remaining words of the burst are accepted
// and discarded (no IM write) until LdLast is seen or LdValid goes low, so
// a loader that keeps streaming cannot overwrite the image it just built.
module im_fetch_ctrl import im_pkg::*; #(
  parameter int          DEPTH    = IM_DEPTH,
  parameter int          ADDR_W   = IM_ADDR_W,
  parameter logic [31:0] RESET_PC = IM_RESET_PC
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              LdValid,
  output logic              LdReady,
  input  logic [31:0]       LdData,
  input  logic              LdLast,
  input  logic              Start,
  input  logic              Stall,
  input  logic              BrTaken,
  input  logic [31:0]       BrTarget,
  input  logic              JmpTaken,
  input  logic [25:0]       Addr26,
  input  logic              HaltReq,
  output logic [31:0]       PC,
  output logic [ADDR_W-1:0] ImAddr,
  output logic              ImWe,
  output logic [31:0]       ImWData,
  output logic              InstValid,
  output logic              Loaded,
  output logic              Halted,
  output logic              Fault
);

  im_state_t         state_reg;
  logic [31:0]       pc_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              loaded_reg;
  logic              halted_reg;
  logic              cool_reg;   // one-cycle LdReady gap after truncation
  logic              drain_reg;  // discarding the tail of an overlong burst

  logic [31:0]       next_pc;
  logic              ld_ready;
  logic              accept;
  logic              im_we;
  logic              last_word;

  im_next_pc u_next_pc (
    .pc        (pc_reg),
    .stall     (Stall),
    .jmp_taken (JmpTaken),
    .addr26    (Addr26),
    .br_taken  (BrTaken),
    .br_target (BrTarget),
    .next_pc   (next_pc)
  );

  assign ld_ready  = ((state_reg == IDLE) || (state_reg == LOAD)) && !cool_reg;
  assign accept    = LdValid && ld_ready;
  assign im_we     = accept && !drain_reg;
  assign last_word = LdLast || (ptr_reg == ADDR_W'(DEPTH - 1));

`ifdef IM_FETCH_BOUNDS_CHECK_EN
  logic fault_reg;
  logic oob;

  assign oob   = |next_pc[31:ADDR_W+2];
  assign Fault = fault_reg;
`else
  assign Fault = 1'b0;
`endif

  // Load FSM, load pointer, PC and status flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      ptr_reg    <= '0;
      loaded_reg <= 1'b0;
      halted_reg <= 1'b0;
      cool_reg   <= 1'b0;
      drain_reg  <= 1'b0;
`ifdef IM_FETCH_BOUNDS_CHECK_EN
      fault_reg  <= 1'b0;
`endif
    end else begin
      cool_reg <= 1'b0;
      case (state_reg)
        IDLE, LOAD: begin
          if (im_we) begin
            if (last_word) begin
              state_reg  <= IDLE;
              loaded_reg <= 1'b1;
              ptr_reg    <= '0;
              if (!LdLast) begin
                cool_reg  <= 1'b1;
                drain_reg <= 1'b1;
              end
            end else begin
              state_reg  <= LOAD;
              loaded_reg <= 1'b0;
              ptr_reg    <= ptr_reg + ADDR_W'(1);
            end
          end else if (accept) begin
            // Tail word of a truncated burst: swallow it.
            if (LdLast) begin
              drain_reg <= 1'b0;
            end
          end else if (state_reg == IDLE) begin
            if (!cool_reg) begin
              drain_reg <= 1'b0;
            end
            if (Start && loaded_reg) begin
              state_reg <= RUN;
              pc_reg    <= RESET_PC;
              drain_reg <= 1'b0;
            end
          end
        end
        RUN: begin
          if (HaltReq) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
`ifdef IM_FETCH_BOUNDS_CHECK_EN
          end else if (oob) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
            fault_reg  <= 1'b1;
            pc_reg     <= next_pc;
`endif
          end else begin
            pc_reg <= next_pc;
          end
        end
        default: begin
          // HALT: frozen until reset.
        end
      endcase
    end
  end

  assign LdReady   = ld_ready;
  assign ImWe      = im_we;
  assign ImWData   = LdData;
  assign ImAddr    = ((state_reg == LOAD) || im_we) ? ptr_reg : pc_reg[ADDR_W+1:2];
  assign PC        = pc_reg;
  assign InstValid = (state_reg == RUN);
  assign Loaded    = loaded_reg;
  assign Halted    = halted_reg;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Self-checking bench for im_fetch_ctrl: directed load/run/halt scenarios
// plus randomized loads and randomized redirect streams checked against a
// small next-PC reference model.
module tb_im_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, LdValid, LdLast, Start, Stall, BrTaken, JmpTaken, HaltReq;
  logic [31:0] LdData, BrTarget;
  logic [25:0] Addr26;
  logic        LdReady, ImWe, InstValid, Loaded, Halted, Fault;
  logic [31:0] PC, ImWData;
  logic [4:0]  ImAddr;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] pc_m;

  always #5 Clk = ~Clk;

  im_fetch_ctrl dut (
    .Clk(Clk), .Rst(Rst), .LdValid(LdValid), .LdReady(LdReady), .LdData(LdData),
    .LdLast(LdLast), .Start(Start), .Stall(Stall), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .JmpTaken(JmpTaken), .Addr26(Addr26), .HaltReq(HaltReq),
    .PC(PC), .ImAddr(ImAddr), .ImWe(ImWe), .ImWData(ImWData),
    .InstValid(InstValid), .Loaded(Loaded), .Halted(Halted), .Fault(Fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    LdValid = 0; LdLast = 0; LdData = 0; Start = 0; Stall = 0;
    BrTaken = 0; BrTarget = 0; JmpTaken = 0; Addr26 = 0; HaltReq = 0;
  endtask

  // Reference next PC from the redirect rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic st,
      input logic jmp, input logic [25:0] a26, input logic br, input logic [31:0] bt);
    if (st)  return pc;
    if (jmp) return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, a26} << 2);
    if (br)  return bt & 32'hFFFF_FFFC;
    return pc + 32'd4;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_ldready"}, {31'd0, LdReady}, 32'd1);
    chk({tag, "_imwe"}, {31'd0, ImWe}, 32'd0);
    chk({tag, "_instvalid"}, {31'd0, InstValid}, 32'd0);
    chk({tag, "_loaded"}, {31'd0, Loaded}, 32'd0);
    chk({tag, "_halted"}, {31'd0, Halted}, 32'd0);
    chk({tag, "_fault"}, {31'd0, Fault}, 32'd0);
  endtask

  task automatic load_word(input string tag, input logic [31:0] data,
                           input logic last, input int exp_addr);
    LdValid = 1; LdData = data; LdLast = last;
    #1;
    chk({tag, "_we"}, {31'd0, ImWe}, 32'd1);
    chk({tag, "_addr"}, {27'd0, ImAddr}, exp_addr);
    chk({tag, "_wdata"}, ImWData, data);
    chk({tag, "_ready"}, {31'd0, LdReady}, 32'd1);
    tick();
    LdValid = 0; LdLast = 0;
  endtask

  task automatic run_step(input string tag, input logic st, input logic jmp,
      input logic [25:0] a26, input logic br, input logic [31:0] bt);
    Stall = st; JmpTaken = jmp; Addr26 = a26; BrTaken = br; BrTarget = bt;
    tick();
    pc_m = model_next(pc_m, st, jmp, a26, br, bt);
    chk({tag, "_pc"}, PC, pc_m);
    chk({tag, "_imaddr"}, {27'd0, ImAddr}, (pc_m >> 2) % 32);
    chk({tag, "_instvalid"}, {31'd0, InstValid}, 32'd1);
    idle_inputs();
  endtask

  initial begin
    int          n, idx, cyc;
    bit          seen_cool, seen_back;
    logic        st, jmp, br;
    logic [25:0] a26;
    logic [31:0] bt, held_pc;

    idle_inputs();
    Rst = 1;
    tick();
    tick();
    check_reset("reset");
    Rst = 0;

    // Four-word burst with LdLast on the last word.
    for (int k = 0; k < 4; k++)
      load_word("load4", 32'h1111_1111 * (k + 1), (k == 3), k);
    chk("load4_loaded", {31'd0, Loaded}, 32'd1);
    chk("load4_ready", {31'd0, LdReady}, 32'd1);
    chk("load4_instvalid", {31'd0, InstValid}, 32'd0);

    // Random-length, random-data burst.
    n = $urandom_range(5, 12);
    for (int k = 0; k < n; k++)
      load_word("loadrnd", $urandom, (k == n - 1), k);
    chk("loadrnd_loaded", {31'd0, Loaded}, 32'd1);

    // 40-word burst without LdLast: only the first 32 land in the IM.
    idx = 0; cyc = 0; seen_cool = 0; seen_back = 0;
    while (idx < 40 && cyc < 200) begin
      logic adv;
      LdValid = 1; LdData = 32'hA000_0000 + idx; LdLast = 0;
      #1;
      chk("trunc_we", {31'd0, ImWe}, (idx < 32) ? 32'd1 : 32'd0);
      if (idx < 32) begin
        chk("trunc_addr", {27'd0, ImAddr}, idx);
        chk("trunc_wdata", ImWData, 32'hA000_0000 + idx);
      end else if (!seen_cool) begin
        chk("trunc_ready_low", {31'd0, LdReady}, 32'd0);
        seen_cool = 1;
      end else if (!seen_back) begin
        chk("trunc_ready_back", {31'd0, LdReady}, 32'd1);
        seen_back = 1;
      end
      adv = LdReady;
      tick();
      if (adv) idx++;
      cyc++;
    end
    chk("trunc_budget", idx, 40);
    idle_inputs();
    tick();
    chk("trunc_loaded", {31'd0, Loaded}, 32'd1);
    chk("trunc_ready_idle", {31'd0, LdReady}, 32'd1);

    // Start: sequential fetch from RESET_PC.
    Start = 1;
    tick();
    Start = 0;
    pc_m = 32'h0;
    chk("start_pc", PC, pc_m);
    chk("start_instvalid", {31'd0, InstValid}, 32'd1);
    for (int k = 0; k < 4; k++)
      run_step("seq", 0, 0, 26'd0, 0, 32'd0);

    // Redirect priorities.
    run_step("br_to8", 0, 0, 26'd0, 1, 32'h8);
    run_step("stall_jmp", 1, 1, 26'h10, 1, 32'h40);
    run_step("jmp_over_br", 0, 1, 26'h10, 1, 32'h40);
    run_step("jmp_over_br2", 0, 1, 26'h3, 1, 32'h20);
    run_step("br_align", 0, 0, 26'd0, 1, 32'h1D);

    // Randomized redirect stream kept inside the IM.
    for (int k = 0; k < 40; k++) begin
      st  = ($urandom % 4) == 0;
      jmp = ($urandom % 3) == 0;
      a26 = 26'($urandom_range(0, 31));
      br  = ($urandom % 2) == 1;
      bt  = ($urandom_range(0, 31) * 4) | ($urandom % 4);
      if (!st && !jmp && !br && pc_m == 32'h7C) br = 1;
      run_step("rnd", st, jmp, a26, br, bt);
    end

    // HaltReq wins over a jump; halt ignores loader and Start.
    held_pc = pc_m;
    HaltReq = 1; JmpTaken = 1; Addr26 = 26'h5;
    tick();
    idle_inputs();
    chk("halt_halted", {31'd0, Halted}, 32'd1);
    chk("halt_instvalid", {31'd0, InstValid}, 32'd0);
    chk("halt_pc", PC, held_pc);
    chk("halt_fault", {31'd0, Fault}, 32'd0);
    Start = 1; LdValid = 1; LdData = 32'hDEAD_BEEF;
    #1;
    chk("halt_ldready", {31'd0, LdReady}, 32'd0);
    chk("halt_imwe", {31'd0, ImWe}, 32'd0);
    tick();
    idle_inputs();
    chk("halt_pc_frozen", PC, held_pc);
    chk("halt_stays", {31'd0, Halted}, 32'd1);
    chk("halt_loaded", {31'd0, Loaded}, 32'd1);
    Rst = 1;
    tick();
    Rst = 0;
    check_reset("rst_from_halt");

    // Start without an image is ignored.
    Start = 1;
    tick();
    Start = 0;
    chk("start_unloaded", {31'd0, InstValid}, 32'd0);

    // Load and Start together: the load wins.
    LdValid = 1; LdLast = 1; LdData = 32'h5555_5555; Start = 1;
    #1;
    chk("ld_vs_start_we", {31'd0, ImWe}, 32'd1);
    chk("ld_vs_start_addr", {27'd0, ImAddr}, 32'd0);
    tick();
    idle_inputs();
    chk("ld_vs_start_instvalid", {31'd0, InstValid}, 32'd0);
    chk("ld_vs_start_loaded", {31'd0, Loaded}, 32'd1);

    // Fetch past the end of the IM.
    Start = 1;
    tick();
    Start = 0;
    pc_m = 32'h0;
    run_step("to_7c", 0, 0, 26'd0, 1, 32'h7C);
`ifdef IM_FETCH_BOUNDS_CHECK_EN
    tick();
    chk("oob_pc", PC, 32'h80);
    chk("oob_fault", {31'd0, Fault}, 32'd1);
    chk("oob_halted", {31'd0, Halted}, 32'd1);
    chk("oob_instvalid", {31'd0, InstValid}, 32'd0);
`else
    run_step("wrap", 0, 0, 26'd0, 0, 32'd0);
    chk("wrap_pc", PC, 32'h80);
    chk("wrap_fault", {31'd0, Fault}, 32'd0);
    chk("wrap_halted", {31'd0, Halted}, 32'd0);
    run_step("wrap_next", 0, 0, 26'd0, 0, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
